// File: rtl/spi_rom_fetch_pkg.sv
// Shared constants and FSM encoding for the SPI ROM read engine.
package spi_rom_fetch_pkg;

  localparam logic [7:0]  CmdRead = 8'h03;
  localparam int unsigned AddrW   = 24;
  localparam int unsigned LenW    = 8;
  localparam int unsigned CsGap   = 4;
  localparam int unsigned GapW    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StGap
  } state_e;

endpackage

// File: rtl/spi_rom_fetch_bit_clock.sv
// clk/2 SCLK generator; the low half stretches while stall_i is high.
module spi_rom_fetch_bit_clock (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic stall_i,
  output logic sclk_o,
  output logic sample_o
);

  logic sclk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= 1'b0;
    end else if (!en_i || sclk_q) begin
      sclk_q <= 1'b0;
    end else if (!stall_i) begin
      sclk_q <= 1'b1;
    end
  end

  assign sclk_o   = sclk_q;
  // The edge that ends the high half samples MISO and shifts MOSI.
  assign sample_o = en_i & sclk_q;

endmodule

// File: rtl/spi_rom_fetch.sv
// SPI flash READ engine: sends 0x03 + 24-bit address, returns bytes through a valid/ready register.
module spi_rom_fetch
  import spi_rom_fetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [LenW-1:0]  req_len_i,
  input  logic             abort_i,
  output logic [7:0]       byte_data_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             spi_cs_o,
  output logic             spi_sclk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i
);

  state_e          state_q;
  logic [31:0]     pre_q;
  logic [7:0]      rx_q, byte_data_q;
  logic [4:0]      bit_cnt_q;
  logic [LenW-1:0] byte_cnt_q;
  logic [GapW-1:0] gap_q;
  logic            pending_q, byte_valid_q, done_q, cs_q, mosi_q;

  logic            active, sample, out_free;
  logic [7:0]      rx_next;

  assign active   = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
  assign out_free = ~byte_valid_q | byte_ready_i;
  assign rx_next  = {rx_q[6:0], spi_miso_i};

  spi_rom_fetch_bit_clock u_bit_clock (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (active & ~abort_i),
    .stall_i  (pending_q),
    .sclk_o   (spi_sclk_o),
    .sample_o (sample)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      rx_q         <= '0;
      byte_data_q  <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      gap_q        <= '0;
      pending_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cs_q         <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (byte_valid_q && byte_ready_i) byte_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (req_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= StCmd;
              cs_q       <= 1'b1;
              mosi_q     <= CmdRead[7];
              pre_q      <= {CmdRead[6:0], req_addr_i, 1'b0};
              bit_cnt_q  <= '0;
              byte_cnt_q <= req_len_i;
              pending_q  <= 1'b0;
            end
          end
        end
        StCmd, StAddr, StData: begin
          if (abort_i) begin
            state_q      <= StGap;
            gap_q        <= GapW'(CsGap - 2);
            cs_q         <= 1'b0;
            mosi_q       <= 1'b0;
            byte_valid_q <= 1'b0;
            pending_q    <= 1'b0;
          end else if (pending_q) begin
            // A completed byte is parked in rx_q until the output register frees.
            if (out_free) begin
              byte_data_q  <= rx_q;
              byte_valid_q <= 1'b1;
              pending_q    <= 1'b0;
              if (byte_cnt_q == '0) begin
                state_q <= StGap;
                gap_q   <= GapW'(CsGap - 2);
                cs_q    <= 1'b0;
              end
            end
          end else if (sample) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (state_q != StData) begin
              pre_q  <= pre_q << 1;
              mosi_q <= pre_q[31];
              if (state_q == StCmd && bit_cnt_q == 5'd7) begin
                state_q   <= StAddr;
                bit_cnt_q <= '0;
              end
              if (state_q == StAddr && bit_cnt_q == 5'd23) begin
                state_q   <= StData;
                bit_cnt_q <= '0;
                mosi_q    <= 1'b0;
              end
            end else begin
              rx_q <= rx_next;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q  <= '0;
                byte_cnt_q <= byte_cnt_q - LenW'(1);
                if (out_free) begin
                  byte_data_q  <= rx_next;
                  byte_valid_q <= 1'b1;
                  if (byte_cnt_q == LenW'(1)) begin
                    state_q <= StGap;
                    gap_q   <= GapW'(CsGap - 2);
                    cs_q    <= 1'b0;
                  end
                end else begin
                  rx_q      <= rx_next;
                  pending_q <= 1'b1;
                end
              end
            end
          end
        end
        StGap: begin
          if (abort_i) byte_valid_q <= 1'b0;
          // Leave only once the final byte has been taken by the consumer.
          if (gap_q != '0) begin
            gap_q <= gap_q - GapW'(1);
          end else if (out_free || abort_i) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle) & ~rst_i;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign byte_data_o  = byte_data_q;
  assign byte_valid_o = byte_valid_q;
  assign spi_cs_o     = cs_q;
  assign spi_mosi_o   = mosi_q;

endmodule

// File: tb/tb_spi_rom_fetch.sv
// Directed bench for spi_rom_fetch with a READ-command flash model and a byte scoreboard.
module tb_spi_rom_fetch;
  import spi_rom_fetch_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AddrW-1:0] req_addr = '0;
  logic [LenW-1:0]  req_len = '0;
  logic             abort = 1'b0;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready = 1'b1;
  logic             busy, done;
  logic             spi_cs, spi_sclk, spi_mosi;
  logic             spi_miso = 1'b0;

  int               n_tests = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               acc = 0;
  logic [7:0]       exp_q[$];

  // flash model state
  int               nrise = 0;
  int               nfall = 0;
  logic [31:0]      flash_rx = '0;
  logic [31:0]      last_rx = '0;
  logic             sclk_prev = 1'b0;

  spi_rom_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .abort_i      (abort),
    .byte_data_o  (byte_data),
    .byte_valid_o (byte_valid),
    .byte_ready_i (byte_ready),
    .busy_o       (busy),
    .done_o       (done),
    .spi_cs_o     (spi_cs),
    .spi_sclk_o   (spi_sclk),
    .spi_mosi_o   (spi_mosi),
    .spi_miso_i   (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash: shifts in MOSI on SCLK rise, drives the next data bit after each fall.
  always @(negedge clk) begin
    logic [7:0] b;
    int         d;
    if (!spi_cs) begin
      nrise    = 0;
      nfall    = 0;
      flash_rx = '0;
      spi_miso = 1'b0;
    end else begin
      if (!sclk_prev && spi_sclk) begin
        if (nrise < 32) flash_rx = {flash_rx[30:0], spi_mosi};
        nrise++;
        if (nrise == 32) last_rx = flash_rx;
      end
      if (sclk_prev && !spi_sclk) begin
        nfall++;
        if (nfall >= 32) begin
          d        = nfall - 32;
          b        = mem_byte(flash_rx[23:0] + 24'(d / 8));
          spi_miso = b[7 - (d % 8)];
        end
      end
    end
    sclk_prev = spi_sclk;
  end

  // Scoreboard: every accepted byte must match the next expected byte.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("byte_data", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] a, input logic [7:0] n, input bit expect_data);
    for (int i = 0; i < 400 && !req_ready; i++) tick();
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
    tick();
    req_valid = 1'b0;
    acc       = cyc;
    if (expect_data) for (int j = 0; j < int'(n); j++) exp_q.push_back(mem_byte(a + 24'(j)));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600 && !done; i++) tick();
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int e1, bad, low;
    bit fell;

    // reset state
    repeat (3) tick();
    check("rst_cs", {31'd0, spi_cs}, 0);
    check("rst_sclk", {31'd0, spi_sclk}, 0);
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_byte", {23'd0, byte_valid, byte_data}, 0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 1);

    // 1: basic read, consumer always ready
    issue(24'h000010, 8'd4, 1'b1);
    check("t1_cs_on", {31'd0, spi_cs}, 1);
    check("t1_sclk_low", {31'd0, spi_sclk}, 0);
    check("t1_busy", {30'd0, busy, req_ready}, 32'd2);
    for (int i = 0; i < 200 && !byte_valid; i++) tick();
    check("t1_first_byte_lat", 32'(cyc - acc), 32'd80);
    for (int i = 0; i < 200 && spi_cs; i++) tick();
    e1 = cyc;
    wait_done("t1_done");
    check("t1_gap_to_done", 32'(cyc - e1), CsGap - 1);
    check("t1_ready_at_done", {31'd0, req_ready}, 1);
    check("t1_preamble", last_rx, {8'h03, 24'h000010});
    tick();
    check("t1_done_pulse", {31'd0, done}, 0);

    // 2: backpressure stalls SCLK with CS held
    byte_ready = 1'b0;
    issue(24'h000123, 8'd3, 1'b1);
    for (int i = 0; i < 200 && !byte_valid; i++) tick();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i >= 20 && (spi_sclk || !spi_cs)) bad++;
    end
    check("t2_stall", 32'(bad), 0);
    check("t2_held_valid", {31'd0, byte_valid}, 1);
    byte_ready = 1'b1;
    wait_done("t2_done");
    check("t2_preamble", last_rx, {8'h03, 24'h000123});

    // 3: abort mid-address, then a clean request
    issue(24'h000200, 8'd2, 1'b0);
    while (cyc < acc + 49) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_cs", {30'd0, spi_cs, spi_sclk}, 0);
    check("t3_abort_busy", {30'd0, busy, byte_valid}, 32'd2);
    wait_done("t3_done");
    issue(24'h0002A0, 8'd2, 1'b1);
    wait_done("t3_redo_done");
    check("t3_preamble", last_rx, {8'h03, 24'h0002A0});

    // 4: zero-length request
    issue(24'h000040, 8'd0, 1'b0);
    check("t4_done", {29'd0, done, req_ready, spi_cs}, 32'd6);
    tick();
    check("t4_done_pulse", {30'd0, done, busy}, 0);

    // 5: asynchronous reset mid-data
    issue(24'h000300, 8'd2, 1'b0);
    while (cyc < acc + 69) tick();
    rst = 1'b1;
    #1;
    check("t5_rst_spi", {29'd0, spi_cs, spi_sclk, spi_mosi}, 0);
    check("t5_rst_out", {21'd0, busy, done, byte_valid, byte_data}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    issue(24'h0007F0, 8'd1, 1'b1);
    wait_done("t5_done");
    check("t5_preamble", last_rx, {8'h03, 24'h0007F0});

    // 6: back-to-back requests keep CS low for exactly the gap
    req_addr  = 24'h000020;
    req_len   = 8'd1;
    req_valid = 1'b1;
    tick();
    exp_q.push_back(mem_byte(24'h000020));
    req_addr = 24'h000030;
    req_len  = 8'd2;
    exp_q.push_back(mem_byte(24'h000030));
    exp_q.push_back(mem_byte(24'h000031));
    fell = 1'b0;
    low  = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!spi_cs) begin
        fell = 1'b1;
        low++;
      end else if (fell) begin
        break;
      end
    end
    req_valid = 1'b0;
    check("t6_cs_gap", 32'(low), CsGap);
    wait_done("t6_done");
    check("t6_preamble", last_rx, {8'h03, 24'h000030});

    tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
